// File: rtl/case_6_mul_pipe_vr.sv
// ---------------------------------------------------------------------------
// case_6_mul_pipe_vr
// Pipelined multiplier with a valid/ready handshake. The pipeline moves only
// when the output slot is empty or being consumed, so backpressure stalls all
// stages together. The full-width product is narrowed (wrap or saturate) in
// the final stage, and a sticky flag records any result that did not fit.
//
// Ports
//   ap_clk     in   clock, rising edge
//   ap_rst_n   in   asynchronous active-low reset
//   ce         in   clock enable; 0 holds all pipeline state
//   in_valid   in   operand pair present
//   in_ready   out  pipeline accepts the pair this cycle (combinational)
//   din0       in   operand 0 [din0_WIDTH]
//   din1       in   operand 1 [din1_WIDTH]
//   out_valid  out  dout holds a result
//   out_ready  in   downstream consumes dout
//   dout       out  registered result [dout_WIDTH]
//   busy       out  at least one stage holds valid data
//   sat_flag   out  sticky: a result was clamped or wrapped
//   sat_clr    in   synchronous clear of sat_flag, independent of ce
// ---------------------------------------------------------------------------
module case_6_mul_pipe_vr #(
    parameter int          ID         = 1,
    parameter int unsigned NUM_STAGE  = 3,
    parameter int unsigned din0_WIDTH = 14,
    parameter int unsigned din1_WIDTH = 12,
    parameter int unsigned dout_WIDTH = 26,
    parameter bit          SIGNED0    = 1'b1,
    parameter bit          SIGNED1    = 1'b1,
    parameter bit          SAT        = 1'b0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  busy,
    output logic                  sat_flag,
    input  logic                  sat_clr
);

    // A mixed-signedness product needs one extra bit to hold both ranges.
    localparam int unsigned MIX        = (SIGNED0 != SIGNED1) ? 1 : 0;
    localparam int unsigned P          = din0_WIDTH + din1_WIDTH + MIX;
    localparam int unsigned E0         = P - din0_WIDTH;
    localparam int unsigned E1         = P - din1_WIDTH;
    localparam bit          RES_SIGNED = SIGNED0 | SIGNED1;

    // Elaboration-time parameter sanity check.
    if (NUM_STAGE < 1 || NUM_STAGE > 4 || dout_WIDTH < 2) begin : g_bad_param
        $error("case_6_mul_pipe_vr ID=%0d: NUM_STAGE must be 1..4, dout_WIDTH >= 2", ID);
    end

    logic                  advance_c;
    logic [NUM_STAGE-1:0]  vld_q, vld_d;
    logic [dout_WIDTH-1:0] dout_q, dout_d;
    logic                  sat_q, sat_d;
    logic                  busy_q, busy_d;
    logic [P-1:0]          op0_ext_c, op1_ext_c, mul_c, fin_prod_c;
    logic [dout_WIDTH-1:0] narrow_c;
    logic                  ovf_c;

    // The whole pipeline moves as one when the output slot can take new data.
    assign advance_c = ce & (~vld_q[NUM_STAGE-1] | out_ready);
    assign in_ready  = advance_c;

    // Extend each operand to P bits per its own signedness; the low P bits of
    // the product are then correct for every signedness combination.
    assign op0_ext_c = {{E0{SIGNED0 & din0[din0_WIDTH-1]}}, din0};
    assign op1_ext_c = {{E1{SIGNED1 & din1[din1_WIDTH-1]}}, din1};
    assign mul_c     = op0_ext_c * op1_ext_c;

    // Full-width product stages ahead of the final (narrowing) stage.
    if (NUM_STAGE > 1) begin : g_pipe
        localparam int unsigned PD = NUM_STAGE - 1;

        logic [P-1:0] pipe_q  [PD];
        logic [P-1:0] pipe_d  [PD];
        logic [P-1:0] pipe_in [PD];

        // Data into each stage: the fresh product or the previous stage.
        always_comb begin
            pipe_in[0] = mul_c;
            for (int s = 1; s < int'(PD); s++) begin
                pipe_in[s] = pipe_q[s-1];
            end
        end

        // Stages only capture data that arrives with a valid bit.
        always_comb begin
            for (int s = 0; s < int'(PD); s++) begin
                pipe_d[s] = pipe_q[s];
                if (advance_c && vld_d[s]) begin
                    pipe_d[s] = pipe_in[s];
                end
            end
        end

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                for (int s = 0; s < int'(PD); s++) begin
                    pipe_q[s] <= '0;
                end
            end else begin
                for (int s = 0; s < int'(PD); s++) begin
                    pipe_q[s] <= pipe_d[s];
                end
            end
        end

        assign fin_prod_c = pipe_q[PD-1];
    end else begin : g_nopipe
        assign fin_prod_c = mul_c;
    end

    // Final-stage narrowing: extend, wrap, or clamp the full product.
    if (dout_WIDTH >= P) begin : g_wide
        if (RES_SIGNED) begin : g_sext
            assign narrow_c = dout_WIDTH'($signed(fin_prod_c));
        end else begin : g_zext
            assign narrow_c = dout_WIDTH'(fin_prod_c);
        end
        assign ovf_c = 1'b0;
    end else begin : g_narrow
        logic [dout_WIDTH-1:0] clamp_c;

        if (RES_SIGNED) begin : g_sgn
            // Representable iff the bits from the new sign bit upward agree.
            logic [P-dout_WIDTH:0] hi_c;
            assign hi_c    = fin_prod_c[P-1:dout_WIDTH-1];
            assign ovf_c   = ~((&hi_c) | ~(|hi_c));
            assign clamp_c = fin_prod_c[P-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                                             : {1'b0, {(dout_WIDTH-1){1'b1}}};
        end else begin : g_uns
            assign ovf_c   = |fin_prod_c[P-1:dout_WIDTH];
            assign clamp_c = '1;
        end

        assign narrow_c = (SAT && ovf_c) ? clamp_c : fin_prod_c[dout_WIDTH-1:0];
    end

    // Valid shift, output capture, sticky flag and busy next-state.
    always_comb begin
        vld_d  = vld_q;
        dout_d = dout_q;
        sat_d  = sat_q;

        if (advance_c) begin
            vld_d = NUM_STAGE'({vld_q, in_valid});
        end

        if (advance_c && vld_d[NUM_STAGE-1]) begin
            dout_d = narrow_c;
        end

        // Clear acts even with ce low; a simultaneous set takes priority.
        if (sat_clr) begin
            sat_d = 1'b0;
        end
        if (advance_c && vld_d[NUM_STAGE-1] && ovf_c) begin
            sat_d = 1'b1;
        end

        busy_d = |vld_d;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_q  <= '0;
            dout_q <= '0;
            sat_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            dout_q <= dout_d;
            sat_q  <= sat_d;
            busy_q <= busy_d;
        end
    end

    assign out_valid = vld_q[NUM_STAGE-1];
    assign dout      = dout_q;
    assign busy      = busy_q;
    assign sat_flag  = sat_q;

endmodule

// File: doc/case_6_mul_pipe_vr.md
CASE_6_MUL_PIPE_VR -- requirements
Module: case_6_mul_pipe_vr

Interface
REQ-001 The module SHALL take parameter ID, default 1: instance tag with no functional effect.
REQ-002 The module SHALL take parameter NUM_STAGE, default 3: pipeline latency in cycles, legal range 1..4.
REQ-003 The module SHALL take parameter din0_WIDTH, default 14: width of operand 0.
REQ-004 The module SHALL take parameter din1_WIDTH, default 12: width of operand 1.
REQ-005 The module SHALL take parameter dout_WIDTH, default 26: width of the result.
REQ-006 The module SHALL take parameters SIGNED0 and SIGNED1, default 1 each: 1 means two's complement, 0 means unsigned, per operand.
REQ-007 The module SHALL take parameter SAT, default 0: 0 wraps (truncates) a narrowed result, 1 saturates it.
REQ-008 ap_clk  in  1  sole clock, rising edge.
REQ-009 ap_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-010 ce  in  1  clock enable; when 0, all state holds.
REQ-011 in_valid  in  1  operand pair present.
REQ-012 in_ready  out  1  pipeline accepts the operand pair this cycle.
REQ-013 din0  in  din0_WIDTH  operand 0.
REQ-014 din1  in  din1_WIDTH  operand 1.
REQ-015 out_valid  out  1  dout holds a result.
REQ-016 out_ready  in  1  downstream consumes dout.
REQ-017 dout  out  dout_WIDTH  registered product.
REQ-018 busy  out  1  at least one pipeline stage holds valid data.
REQ-019 sat_flag  out  1  sticky flag: a result was clamped or wrapped.
REQ-020 sat_clr  in  1  synchronous clear of sat_flag.

Function
REQ-021 The module SHALL define advance = ce & (~out_valid | out_ready) and drive in_ready = advance combinationally.
REQ-022 An operand pair SHALL be accepted exactly when in_valid & in_ready.
REQ-023 On advance, every stage SHALL shift data and valid by one stage; stage-0 valid loads in_valid.
REQ-024 When advance is 0, all stages SHALL hold, including during out_valid & ~out_ready backpressure or ce=0.
REQ-025 A result SHALL appear on out_valid/dout exactly NUM_STAGE advancing cycles after acceptance.
REQ-026 Throughput SHALL be one result per cycle while advance stays 1; bubbles (in_valid=0) SHALL propagate as invalid stages.
REQ-027 The product SHALL be computed at full width P = din0_WIDTH + din1_WIDTH, plus one bit when SIGNED0 != SIGNED1; each operand is extended per its SIGNEDx.
REQ-028 The result SHALL be signed if SIGNED0 | SIGNED1, otherwise unsigned.
REQ-029 If dout_WIDTH >= P, dout SHALL be the sign- or zero-extended product.
REQ-030 If dout_WIDTH < P and SAT=0, dout SHALL carry the low dout_WIDTH bits.
REQ-031 If dout_WIDTH < P and SAT=1, dout SHALL clamp to the representable max or min.
REQ-032 Narrowing and saturation SHALL be evaluated in the final stage.
REQ-033 sat_flag SHALL set on the cycle a valid result leaves the final stage with a product unrepresentable in dout_WIDTH, in either SAT mode.
REQ-034 If set and sat_clr are simultaneous, set SHALL win; sat_clr SHALL act regardless of ce.
REQ-035 busy SHALL be the OR of all stage valid bits.
REQ-036 dout SHALL be stable while out_valid & ~out_ready.

Reset
REQ-037 Asserting ap_rst_n low SHALL asynchronously clear all valid bits, sat_flag, and dout to 0.
REQ-038 After reset: out_valid=0, busy=0, and in_ready follows ce.
REQ-039 Reset mid-operation SHALL discard all in-flight results; nothing SHALL emerge after release.
REQ-040 Deassertion SHALL be synchronised externally; the block SHALL resume normal operation from the first rising edge with ap_rst_n=1.

Verification
REQ-041 Defaults: din0=-8192, din1=-2048, out_ready=1 -> after 3 cycles out_valid=1, dout=16777216 (0x1000000), sat_flag=0.
REQ-042 SIGNED0=SIGNED1=0: din0=0x3FFF, din1=0xFFF -> dout=67088385.
REQ-043 dout_WIDTH=16, SAT=1: 8191*2047 -> dout=32767 and sat_flag=1; sat_clr then clears sat_flag to 0.
REQ-044 dout_WIDTH=16, SAT=0: 8191*2047 -> dout=0xD801 and sat_flag=1.
REQ-045 Backpressure: stream 5 pairs with out_ready=0 from cycle 4 for 3 cycles -> in_ready=0 and dout held; all 5 results are delivered in order with no loss or duplication.
REQ-046 ap_rst_n low with 3 pairs in flight -> out_valid=0 and busy=0 immediately; no results appear after release.
